// File: rtl/adder_pkg.sv
// Shared definitions for the adders library: controller state encoding and
// the default datapath width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_using_half_adder.sv
// 1-bit full-adder cell built from two half-adder stages and an OR for the
// carry; the only arithmetic element of the serial adder.
module full_adder_using_half_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic hs1_s;
    logic hc1_s;
    logic hc2_s;

    assign hs1_s = a ^ b;
    assign hc1_s = a & b;
    assign sum   = hs1_s ^ cin;
    assign hc2_s = hs1_s & cin;
    assign cout  = hc1_s | hc2_s;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell processes the operands
// LSB-first, one bit per clock, and returns sum/cout/ovf via a done/ack handshake.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic               cmsb_r;
    logic               busy_r;
    logic               done_r;
    logic               cout_r;
    logic               ovf_r;
    logic               fa_sum_s;
    logic               fa_cout_s;

    full_adder_using_half_adder u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Controller FSM together with the operand/result shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            cmsb_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
                    carry_r <= fa_cout_s;
                    if (cnt_r == CNT_MSB) begin
                        cmsb_r <= fa_cout_s;
                    end
                    // Last bit: the counter stops here so it never wraps.
                    if (cnt_r == CNT_LAST) begin
                        cout_r  <= fa_cout_s;
                        ovf_r   <= cmsb_r ^ fa_cout_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        done_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule
